// File: rtl/pyrite_bpi_pkg.sv
// Shared definitions for the BPI NOR flash sequencer: state encoding,
// wait-counter type and default pin-timing constants.
package pyrite_bpi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RD,
        ST_WR,
        ST_WR_HOLD,
        ST_TURN
    } state_t;

    typedef logic [7:0] cnt_t;

    localparam int unsigned DEF_FLASH_ADDR_W = 25;
    localparam int unsigned DEF_FLASH_DATA_W = 16;
    localparam int unsigned DEF_FLASH_RGN_W  = 1;
    localparam int unsigned DEF_T_ADV        = 2;
    localparam int unsigned DEF_T_RD         = 8;
    localparam int unsigned DEF_T_WR         = 6;
    localparam int unsigned DEF_T_TURN       = 2;

    // A state lasting N cycles loads N-1 and leaves when the counter reads zero.
    function automatic cnt_t wait_load(input int unsigned cycles);
        return cnt_t'(cycles - 1);
    endfunction

endpackage

// File: rtl/pyrite_bpi_flash_seq.sv
// BPI NOR flash sequencer: turns one valid/ready command into a complete
// CE#/ADV#/OE#/WE# bus cycle with programmable wait states. Every output
// is a flop so the flash pins never see a combinational path.
module pyrite_bpi_flash_seq
    import pyrite_bpi_pkg::*;
#(
    parameter int unsigned FLASH_ADDR_W = DEF_FLASH_ADDR_W,
    parameter int unsigned FLASH_DATA_W = DEF_FLASH_DATA_W,
    parameter int unsigned FLASH_RGN_W  = DEF_FLASH_RGN_W,
    parameter int unsigned T_ADV        = DEF_T_ADV,
    parameter int unsigned T_RD         = DEF_T_RD,
    parameter int unsigned T_WR         = DEF_T_WR,
    parameter int unsigned T_TURN       = DEF_T_TURN
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [FLASH_RGN_W+FLASH_ADDR_W-1:0] cmd_addr,
    input  logic [FLASH_DATA_W-1:0]         cmd_wdata,
    output logic                            rsp_valid,
    output logic [FLASH_DATA_W-1:0]         rsp_rdata,
    output logic                            busy,
    input  logic [FLASH_DATA_W-1:0]         flash_dq_i,
    output logic [FLASH_DATA_W-1:0]         flash_dq_o,
    output logic                            flash_dq_oe,
    output logic [FLASH_ADDR_W-1:0]         flash_addr,
    output logic [FLASH_RGN_W-1:0]          flash_region,
    output logic                            flash_region_oe,
    output logic                            flash_ce_n,
    output logic                            flash_oe_n,
    output logic                            flash_we_n,
    output logic                            flash_adv_n
);

    // Wait-state counts outside 1..255 cannot be held by the 8-bit counter.
    if (T_ADV == 0 || T_ADV > 255 || T_RD == 0 || T_RD > 255 ||
        T_WR == 0 || T_WR > 255 || T_TURN == 0 || T_TURN > 255) begin : g_bad_timing
        $error("pyrite_bpi_flash_seq: timing parameters must lie in 1..255");
    end

    state_t                  state;
    cnt_t                    cnt;
    logic                    wr_q;
    logic [FLASH_DATA_W-1:0] wdata_q;

    // Single sequencing FSM; each pin is updated on the state transition
    // that enters the phase where it changes, so outputs stay registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            wr_q            <= 1'b0;
            wdata_q         <= '0;
            cmd_ready       <= 1'b0;
            busy            <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            flash_dq_o      <= '0;
            flash_dq_oe     <= 1'b0;
            flash_addr      <= '0;
            flash_region    <= '0;
            flash_region_oe <= 1'b0;
            flash_ce_n      <= 1'b1;
            flash_oe_n      <= 1'b1;
            flash_we_n      <= 1'b1;
            flash_adv_n     <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        wr_q            <= cmd_write;
                        wdata_q         <= cmd_wdata;
                        flash_addr      <= cmd_addr[FLASH_ADDR_W-1:0];
                        flash_region    <= cmd_addr[FLASH_ADDR_W +: FLASH_RGN_W];
                        flash_region_oe <= 1'b1;
                        flash_ce_n      <= 1'b0;
                        flash_adv_n     <= 1'b0;
                        cmd_ready       <= 1'b0;
                        busy            <= 1'b1;
                        cnt             <= wait_load(T_ADV);
                        state           <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        flash_adv_n <= 1'b1;
                        if (wr_q) begin
                            flash_we_n  <= 1'b0;
                            flash_dq_oe <= 1'b1;
                            flash_dq_o  <= wdata_q;
                            cnt         <= wait_load(T_WR);
                            state       <= ST_WR;
                        end else begin
                            flash_oe_n <= 1'b0;
                            cnt        <= wait_load(T_RD);
                            state      <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_rdata       <= flash_dq_i;
                        rsp_valid       <= 1'b1;
                        flash_ce_n      <= 1'b1;
                        flash_oe_n      <= 1'b1;
                        flash_region_oe <= 1'b0;
                        cnt             <= wait_load(T_TURN);
                        state           <= ST_TURN;
                    end
                end
                ST_WR: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        flash_we_n <= 1'b1;
                        cnt        <= '0;
                        state      <= ST_WR_HOLD;
                    end
                end
                ST_WR_HOLD: begin
                    rsp_valid       <= 1'b1;
                    flash_ce_n      <= 1'b1;
                    flash_dq_oe     <= 1'b0;
                    flash_region_oe <= 1'b0;
                    cnt             <= wait_load(T_TURN);
                    state           <= ST_TURN;
                end
                ST_TURN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pyrite_bpi_flash_seq.sv
// Self-checking bench for pyrite_bpi_flash_seq. Two instances share the
// stimulus: one with default timing, one with every wait count at 1; a
// select bit chooses which one is compared against the reference model.
module tb_pyrite_bpi_flash_seq;

    typedef struct packed {
        logic        cmd_ready;
        logic        busy;
        logic        rsp_valid;
        logic [15:0] rsp_rdata;
        logic        ce_n;
        logic        oe_n;
        logic        we_n;
        logic        adv_n;
        logic        dq_oe;
        logic [15:0] dq_o;
        logic [24:0] addr;
        logic [0:0]  region;
        logic        region_oe;
    } pins_t;

    typedef struct {
        logic        wr;
        logic [25:0] addr;
        logic [15:0] wdata;
        logic [15:0] dq;
        logic [15:0] exp_rdata;
        int          exp_rsp;
        int          exp_rdy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_write;
    logic [25:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic [15:0] flash_dq_i;
    logic        sel;

    wire pins_t  d_pins;
    wire pins_t  m_pins;
    pins_t       cur;

    // Reference model state: k counts cycles into the current transaction (0 = idle).
    int          ta, tr, tw, tt;
    int          k;
    logic        m_wr;
    logic [25:0] m_caddr;
    logic [15:0] m_wdata, m_rdata, m_dqo;
    logic        m_rdy;
    bit          acc;
    int          cyc;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[4];

    always #5 clk = ~clk;

    assign cur = sel ? m_pins : d_pins;

    pyrite_bpi_flash_seq dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(d_pins.cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(d_pins.rsp_valid), .rsp_rdata(d_pins.rsp_rdata), .busy(d_pins.busy),
        .flash_dq_i(flash_dq_i), .flash_dq_o(d_pins.dq_o), .flash_dq_oe(d_pins.dq_oe),
        .flash_addr(d_pins.addr), .flash_region(d_pins.region),
        .flash_region_oe(d_pins.region_oe), .flash_ce_n(d_pins.ce_n),
        .flash_oe_n(d_pins.oe_n), .flash_we_n(d_pins.we_n), .flash_adv_n(d_pins.adv_n)
    );

    pyrite_bpi_flash_seq #(
        .T_ADV(1), .T_RD(1), .T_WR(1), .T_TURN(1)
    ) dut_min (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(m_pins.cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(m_pins.rsp_valid), .rsp_rdata(m_pins.rsp_rdata), .busy(m_pins.busy),
        .flash_dq_i(flash_dq_i), .flash_dq_o(m_pins.dq_o), .flash_dq_oe(m_pins.dq_oe),
        .flash_addr(m_pins.addr), .flash_region(m_pins.region),
        .flash_region_oe(m_pins.region_oe), .flash_ce_n(m_pins.ce_n),
        .flash_oe_n(m_pins.oe_n), .flash_we_n(m_pins.we_n), .flash_adv_n(m_pins.adv_n)
    );

    function automatic int txnLen(logic wr);
        return wr ? (ta + tw + 1 + tt) : (ta + tr + tt);
    endfunction

    // Advance the transaction-level model by one rising edge.
    task automatic modelEdge();
        acc = 1'b0;
        if (!rst_n) begin
            k = 0; m_rdy = 1'b0; m_caddr = '0; m_rdata = '0; m_dqo = '0;
        end else if (k == 0) begin
            if (cmd_valid && m_rdy) begin
                m_wr = cmd_write; m_caddr = cmd_addr; m_wdata = cmd_wdata;
                k = 1; m_rdy = 1'b0; acc = 1'b1;
            end else begin
                m_rdy = 1'b1;
            end
        end else begin
            if (!m_wr && k == ta + tr) m_rdata = flash_dq_i;
            if (m_wr && k == ta) m_dqo = m_wdata;
            if (k == txnLen(m_wr)) begin
                k = 0; m_rdy = 1'b1;
            end else begin
                k = k + 1;
            end
        end
    endtask

    // Expected pins from the phase rules: address, strobe, data-hold, turnaround.
    function automatic pins_t expectPins();
        pins_t e;
        e.cmd_ready = m_rdy; e.busy = (k != 0); e.rsp_valid = 1'b0; e.rsp_rdata = m_rdata;
        e.ce_n = 1'b1; e.oe_n = 1'b1; e.we_n = 1'b1; e.adv_n = 1'b1; e.dq_oe = 1'b0;
        e.dq_o = m_dqo; e.addr = m_caddr[24:0]; e.region = m_caddr[25]; e.region_oe = 1'b0;
        if (k >= 1 && k <= ta) begin
            e.ce_n = 1'b0; e.adv_n = 1'b0; e.region_oe = 1'b1;
        end else if (k > ta && !m_wr) begin
            if (k <= ta + tr) begin
                e.ce_n = 1'b0; e.oe_n = 1'b0; e.region_oe = 1'b1;
            end else begin
                e.rsp_valid = (k == ta + tr + 1);
            end
        end else if (k > ta && m_wr) begin
            if (k <= ta + tw) begin
                e.ce_n = 1'b0; e.we_n = 1'b0; e.dq_oe = 1'b1; e.region_oe = 1'b1;
            end else if (k == ta + tw + 1) begin
                e.ce_n = 1'b0; e.dq_oe = 1'b1; e.region_oe = 1'b1;
            end else begin
                e.rsp_valid = (k == ta + tw + 2);
            end
        end
        return e;
    endfunction

    task automatic checkVal(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic checkOutput(string tag);
        pins_t e;
        e = expectPins();
        checks++;
        if (cur !== e) begin
            errors++;
            $display("[TB] FAIL pins %s cycle %0d sel %0d: got %h expected %h", tag, cyc, sel, cur, e);
        end
        checks++;
        if ((!cur.oe_n && cur.dq_oe) || (!cur.oe_n && !cur.we_n) ||
            (!cur.adv_n && (!cur.oe_n || !cur.we_n))) begin
            errors++;
            $display("[TB] FAIL overlap %s cycle %0d: got ce%b oe%b we%b adv%b dqoe%b expected no overlap",
                     tag, cyc, cur.ce_n, cur.oe_n, cur.we_n, cur.adv_n, cur.dq_oe);
        end
    endtask

    task automatic applyStimulus(string tag);
        @(posedge clk);
        modelEdge();
        #1;
        cyc++;
        checkOutput(tag);
    endtask

    task automatic setSel(logic s);
        sel = s;
        if (s) begin
            ta = 1; tr = 1; tw = 1; tt = 1;
        end else begin
            ta = 2; tr = 8; tw = 6; tt = 2;
        end
    endtask

    task automatic doReset(int n);
        rst_n = 1'b0; cmd_valid = 1'b0;
        repeat (n) applyStimulus("reset");
        rst_n = 1'b1;
    endtask

    task automatic waitReady();
        int guard = 0;
        cmd_valid = 1'b0;
        while (!m_rdy && guard < 50) begin
            applyStimulus("wait_ready");
            guard++;
        end
    endtask

    // One directed command: latency of rsp_valid and cmd_ready, data, strobe widths.
    task automatic runVector(vec_t v, string name);
        int off, rsp_off, rdy_off, nadv, noe, nwe;
        logic [15:0] got_rd;
        waitReady();
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; flash_dq_i = v.dq;
        applyStimulus(name);
        cmd_valid = 1'b0;
        off = 1; rsp_off = -1; rdy_off = -1; nadv = 0; noe = 0; nwe = 0; got_rd = 16'h0;
        while (rdy_off < 0 && off < 40) begin
            if (cur.rsp_valid && rsp_off < 0) begin
                rsp_off = off; got_rd = cur.rsp_rdata;
            end
            if (!cur.adv_n) nadv++;
            if (!cur.oe_n) noe++;
            if (!cur.we_n) nwe++;
            if (cur.cmd_ready) begin
                rdy_off = off;
            end else begin
                applyStimulus(name);
                off++;
            end
        end
        checkVal({name, "_rsp_cycle"}, rsp_off, v.exp_rsp);
        checkVal({name, "_ready_cycle"}, rdy_off, v.exp_rdy);
        checkVal({name, "_rdata"}, int'(got_rd), int'(v.exp_rdata));
        checkVal({name, "_adv_low"}, nadv, ta);
        checkVal({name, "_oe_low"}, noe, v.wr ? 0 : tr);
        checkVal({name, "_we_low"}, nwe, v.wr ? tw : 0);
    endtask

    // Random command mix; commands are held until the handshake completes.
    task automatic runRandom(int n);
        int nacc = 0, nrsp = 0, budget = n * 20 + 100;
        cmd_valid = 1'b0;
        while (nacc < n && budget > 0) begin
            budget--;
            if (!cmd_valid && $urandom_range(0, 3) != 0) begin
                cmd_valid = 1'b1;
                cmd_write = 1'($urandom_range(0, 1));
                cmd_addr  = 26'($urandom);
                cmd_wdata = 16'($urandom);
            end
            flash_dq_i = 16'($urandom);
            applyStimulus("random");
            if (cur.rsp_valid) nrsp++;
            if (acc) begin
                nacc++;
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        repeat (30) begin
            flash_dq_i = 16'($urandom);
            applyStimulus("drain");
            if (cur.rsp_valid) nrsp++;
        end
        checkVal("random_accepts", nacc, n);
        checkVal("random_responses", nrsp, n);
    endtask

    initial begin
        int nrise, nrsp, first, second;
        logic prev_busy;

        vecs[0] = '{1'b0, 26'h1000123, 16'h0000, 16'hA5C3, 16'hA5C3, 11, 13};
        vecs[1] = '{1'b1, 26'h0000055, 16'h00E8, 16'h7777, 16'hA5C3, 10, 12};
        vecs[2] = '{1'b0, 26'h0ABCDEF, 16'h0000, 16'h1234, 16'h1234, 11, 13};
        vecs[3] = '{1'b1, 26'h1FFFFFF, 16'hFFFF, 16'h0F0F, 16'h1234, 10, 12};

        cyc = 0; k = 0; m_rdy = 1'b0; m_wr = 1'b0; m_caddr = '0;
        m_wdata = '0; m_rdata = '0; m_dqo = '0;
        cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; flash_dq_i = '0;
        setSel(1'b0);
        doReset(3);

        for (int i = 0; i < 4; i++) begin
            runVector(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back reads with cmd_valid held: second start exactly when ready returns.
        waitReady();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 26'h0000200; flash_dq_i = 16'h5A5A;
        nrise = 0; nrsp = 0; first = -1; second = -1; prev_busy = cur.busy;
        for (int i = 0; i < 40; i++) begin
            applyStimulus("b2b");
            if (cur.busy && !prev_busy) begin
                nrise++;
                if (nrise == 1) first = cyc;
                else begin
                    second = cyc;
                    cmd_valid = 1'b0;
                end
            end
            prev_busy = cur.busy;
            if (cur.rsp_valid) nrsp++;
        end
        checkVal("b2b_starts", nrise, 2);
        checkVal("b2b_gap", second - first, 13);
        checkVal("b2b_responses", nrsp, 2);

        // Reset asserted in the third RD cycle aborts the read silently.
        waitReady();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 26'h0000777; flash_dq_i = 16'hBEEF;
        applyStimulus("abort");
        cmd_valid = 1'b0;
        repeat (4) applyStimulus("abort");
        rst_n = 1'b0;
        applyStimulus("abort_rst");
        checkVal("abort_pins", int'({cur.ce_n, cur.oe_n, cur.we_n, cur.adv_n, cur.dq_oe, cur.rsp_valid}), 'b111100);
        applyStimulus("abort_rst");
        rst_n = 1'b1;
        nrsp = 0;
        repeat (20) begin
            applyStimulus("abort_idle");
            if (cur.rsp_valid) nrsp++;
        end
        checkVal("abort_no_rsp", nrsp, 0);
        runVector(vecs[2], "post_reset_read");

        runRandom(60);

        setSel(1'b1);
        doReset(2);
        runVector('{1'b0, 26'h1000123, 16'h0000, 16'hA5C3, 16'hA5C3, 3, 4}, "min_read");
        runVector('{1'b1, 26'h0000055, 16'h00E8, 16'h0000, 16'hA5C3, 4, 5}, "min_write");
        runRandom(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
